// File: rtl/config_frame_store.sv
// config_frame_store: parses framed UART configuration bytes into a shadow
// bank and commits them atomically by flipping between two RAM banks, so
// downstream generators never observe a half-written configuration.
// Optional feature macro: CFG_CHECKSUM_EN (trailing XOR checksum byte that
// must match before a frame is committed).
module config_frame_store #(
  parameter int NUM_CH       = 8,
  parameter int NUM_ALINE    = 16,
  parameter int WORD_W       = 16,
  parameter int TIMEOUT_CYC  = 1000000,
  localparam int AS_W        = $clog2(NUM_ALINE) + 1,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AL_W        = $clog2(NUM_ALINE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        uart_data,
  input  logic              new_data,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [AL_W-1:0]   rd_aline,
  output logic [WORD_W-1:0] rd_data,
  output logic              intaking_configs,
  output logic [NUM_CH-1:0] channel_select,
  output logic [AS_W-1:0]   aline_select,
  output logic [31:0]       pulse_shape,
  output logic              cfg_valid,
  output logic              frame_ok,
  output logic              frame_err
);

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int BPW    = WORD_W / 8;
  localparam int BC_W   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int NWORDS = NUM_CH * NUM_ALINE;
  localparam int WC_W   = CH_W + AL_W;
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int DEPTH  = 2 ** (WC_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_CHK,
    S_COMMIT
  } state_t;

  state_t state_reg, state_next;

  logic              new_data_q;
  logic              byte_stb;
  logic [2:0]        hdr_cnt_reg;
  logic [BC_W-1:0]   byte_cnt_reg;
  logic [WC_W-1:0]   word_cnt_reg;
  logic [TO_W-1:0]   timeout_cnt_reg;
  logic [NUM_CH-1:0] ch_shadow_reg;
  logic [AS_W-1:0]   al_shadow_reg;
  logic [31:0]       ps_shadow_reg;
  logic [WORD_W-1:0] word_assembled;

  logic              bank_ptr_reg;
  logic [NUM_CH-1:0] channel_select_reg;
  logic [AS_W-1:0]   aline_select_reg;
  logic [31:0]       pulse_shape_reg;
  logic              cfg_valid_reg;
  logic              frame_ok_reg;
  logic              frame_err_reg;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] ram_q;
  logic              rd_mask_reg;
  logic              ch_in_range;

  logic hdr_last, word_byte_last, word_last, in_frame, timed_out;
  logic start_frame, commit, abort, ram_we;

`ifdef CFG_CHECKSUM_EN
  logic [7:0] csum_reg;
`endif

  // A byte is taken only on the rising edge of the UART valid level
  assign byte_stb       = new_data & ~new_data_q;
  assign hdr_last       = (hdr_cnt_reg == 3'd5);
  assign word_byte_last = (byte_cnt_reg == BC_W'(BPW - 1));
  assign word_last      = (word_cnt_reg == WC_W'(NWORDS - 1));
  assign in_frame       = (state_reg == S_HDR) || (state_reg == S_PAYLOAD) ||
                          (state_reg == S_CHK);
  assign timed_out      = in_frame && !byte_stb &&
                          (timeout_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and control decode for the frame parser
  always_comb begin
    state_next  = state_reg;
    start_frame = 1'b0;
    commit      = 1'b0;
    abort       = 1'b0;
    ram_we      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (byte_stb && uart_data == SYNC) begin
          state_next  = S_HDR;
          start_frame = 1'b1;
        end
      end
      S_HDR: begin
        if (timed_out)                 abort = 1'b1;
        else if (byte_stb && hdr_last) state_next = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (timed_out) begin
          abort = 1'b1;
        end else if (byte_stb && word_byte_last) begin
          ram_we = 1'b1;
`ifdef CFG_CHECKSUM_EN
          if (word_last) state_next = S_CHK;
`else
          if (word_last) state_next = S_COMMIT;
`endif
        end
      end
`ifdef CFG_CHECKSUM_EN
      S_CHK: begin
        if (timed_out) begin
          abort = 1'b1;
        end else if (byte_stb) begin
          if (csum_reg == uart_data) state_next = S_COMMIT;
          else                       abort = 1'b1;
        end
      end
`endif
      S_COMMIT: begin
        commit = 1'b1;
        // A byte landing here is treated exactly like one seen in IDLE
        if (byte_stb && uart_data == SYNC) begin
          state_next  = S_HDR;
          start_frame = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  // Byte edge detect, frame counters and header shadow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      new_data_q    <= 1'b0;
      hdr_cnt_reg   <= '0;
      byte_cnt_reg  <= '0;
      word_cnt_reg  <= '0;
      ch_shadow_reg <= '0;
      al_shadow_reg <= '0;
      ps_shadow_reg <= '0;
    end else begin
      new_data_q <= new_data;
      if (start_frame) begin
        hdr_cnt_reg  <= '0;
        byte_cnt_reg <= '0;
        word_cnt_reg <= '0;
      end else if (byte_stb && state_reg == S_HDR) begin
        hdr_cnt_reg <= hdr_cnt_reg + 3'd1;
        case (hdr_cnt_reg)
          3'd0:    ch_shadow_reg <= uart_data[NUM_CH-1:0];
          3'd1:    al_shadow_reg <= uart_data[AS_W-1:0];
          default: ps_shadow_reg <= {ps_shadow_reg[23:0], uart_data};
        endcase
      end else if (byte_stb && state_reg == S_PAYLOAD) begin
        byte_cnt_reg <= word_byte_last ? '0 : byte_cnt_reg + BC_W'(1);
        if (word_byte_last) word_cnt_reg <= word_cnt_reg + WC_W'(1);
      end
    end
  end

  // Words are built MSB first; the final byte completes the word in place
  generate
    if (BPW == 1) begin : g_word_single
      assign word_assembled = uart_data;
    end else begin : g_word_multi
      logic [WORD_W-9:0] word_shift_reg;
      // Shift in the leading bytes of the current word
      always_ff @(posedge clk) begin
        if (rst)
          word_shift_reg <= '0;
        else if (byte_stb && state_reg == S_PAYLOAD)
          word_shift_reg <= word_assembled[WORD_W-9:0];
      end
      assign word_assembled = {word_shift_reg, uart_data};
    end
  endgenerate

`ifdef CFG_CHECKSUM_EN
  // Running XOR over every byte after SYNC up to the checksum byte
  always_ff @(posedge clk) begin
    if (rst || start_frame)
      csum_reg <= '0;
    else if (byte_stb && (state_reg == S_HDR || state_reg == S_PAYLOAD))
      csum_reg <= csum_reg ^ uart_data;
  end
`endif

  // Inter-byte idle counter, active only while a frame is open
  always_ff @(posedge clk) begin
    if (rst || !in_frame || byte_stb)
      timeout_cnt_reg <= '0;
    else
      timeout_cnt_reg <= timeout_cnt_reg + TO_W'(1);
  end

  // Committed configuration, bank pointer and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_ptr_reg       <= 1'b0;
      channel_select_reg <= '0;
      aline_select_reg   <= '0;
      pulse_shape_reg    <= '0;
      cfg_valid_reg      <= 1'b0;
      frame_ok_reg       <= 1'b0;
      frame_err_reg      <= 1'b0;
    end else begin
      frame_ok_reg  <= commit;
      frame_err_reg <= abort;
      if (commit) begin
        bank_ptr_reg       <= ~bank_ptr_reg;
        channel_select_reg <= ch_shadow_reg;
        aline_select_reg   <= al_shadow_reg;
        pulse_shape_reg    <= ps_shadow_reg;
        cfg_valid_reg      <= 1'b1;
      end
    end
  end

  // Ping-pong word RAM: writes go to the shadow bank, reads to the active one
  always_ff @(posedge clk) begin
    if (ram_we) mem[{~bank_ptr_reg, word_cnt_reg}] <= word_assembled;
    ram_q <= mem[{bank_ptr_reg, rd_ch, rd_aline}];
  end

  // Out-of-range channel indices only exist when NUM_CH is not a power of two
  generate
    if (NUM_CH == (1 << CH_W)) begin : g_ch_full
      assign ch_in_range = 1'b1;
    end else begin : g_ch_part
      assign ch_in_range = (rd_ch < CH_W'(NUM_CH));
    end
  endgenerate

  // Read qualifier aligned with the registered RAM output
  always_ff @(posedge clk) begin
    if (rst) rd_mask_reg <= 1'b0;
    else     rd_mask_reg <= cfg_valid_reg & ch_in_range;
  end

  assign rd_data          = rd_mask_reg ? ram_q : '0;
  assign intaking_configs = (state_reg != S_IDLE);
  assign channel_select   = channel_select_reg;
  assign aline_select     = aline_select_reg;
  assign pulse_shape      = pulse_shape_reg;
  assign cfg_valid        = cfg_valid_reg;
  assign frame_ok         = frame_ok_reg;
  assign frame_err        = frame_err_reg;

endmodule

// File: tb/tb_config_frame_store.sv
// tb_config_frame_store: table-driven and randomized frame tests for
// config_frame_store with a small configuration (2 channels x 2 A-lines).
// Honours CFG_CHECKSUM_EN the same way the design does.
module tb_config_frame_store;

  localparam int NUM_CH      = 2;
  localparam int NUM_ALINE   = 2;
  localparam int WORD_W      = 16;
  localparam int TIMEOUT_CYC = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  uart_data = 8'h00;
  logic        new_data = 1'b0;
  logic        rd_ch = 1'b0;
  logic        rd_aline = 1'b0;
  logic [15:0] rd_data;
  logic        intaking_configs;
  logic [1:0]  channel_select;
  logic [1:0]  aline_select;
  logic [31:0] pulse_shape;
  logic        cfg_valid;
  logic        frame_ok;
  logic        frame_err;

  config_frame_store #(
    .NUM_CH(NUM_CH), .NUM_ALINE(NUM_ALINE), .WORD_W(WORD_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .uart_data(uart_data), .new_data(new_data),
    .rd_ch(rd_ch), .rd_aline(rd_aline), .rd_data(rd_data),
    .intaking_configs(intaking_configs), .channel_select(channel_select),
    .aline_select(aline_select), .pulse_shape(pulse_shape),
    .cfg_valid(cfg_valid), .frame_ok(frame_ok), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Configuration as sent on the wire; word index = ch*NUM_ALINE + aline
  typedef struct packed {
    logic [7:0]       chb;
    logic [7:0]       alb;
    logic [31:0]      ps;
    logic [3:0][15:0] w;
  } cfg_t;

  typedef struct packed {
    logic        ch;
    logic        al;
    logic [15:0] exp;
  } rd_vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ok_cnt = 0;
  int err_cnt = 0;

  cfg_t       mdl;
  bit         mdl_valid = 1'b0;
  logic [7:0] frame_q [$];
`ifdef CFG_CHECKSUM_EN
  logic [7:0] csum_flip = 8'h00;
`endif

  // Pulse monitor
  always @(negedge clk) begin
    if (frame_ok)  ok_cnt++;
    if (frame_err) err_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.chb = 8'($urandom);
    c.alb = 8'($urandom);
    c.ps  = $urandom;
    for (int i = 0; i < 4; i++) c.w[i] = 16'($urandom);
    return c;
  endfunction

  task automatic build_frame(input cfg_t c);
    logic [7:0] x;
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(c.chb);
    frame_q.push_back(c.alb);
    for (int i = 3; i >= 0; i--) frame_q.push_back(c.ps[8*i +: 8]);
    for (int i = 0; i < 4; i++) begin
      frame_q.push_back(c.w[i][15:8]);
      frame_q.push_back(c.w[i][7:0]);
    end
    x = 8'h00;
    for (int i = 1; i < frame_q.size(); i++) x = x ^ frame_q[i];
`ifdef CFG_CHECKSUM_EN
    frame_q.push_back(x ^ csum_flip);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(negedge clk);
    uart_data = b;
    new_data  = 1'b1;
    repeat (hold) @(negedge clk);
    new_data  = 1'b0;
    uart_data = 8'($urandom);
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_range(input int first, input int last, input int hlo, input int hhi,
                            input int glo, input int ghi);
    for (int i = first; i <= last; i++)
      send_byte(frame_q[i], $urandom_range(hhi, hlo), $urandom_range(ghi, glo));
  endtask

  // Compare committed outputs and every word against the model
  task automatic check_all(input string tag);
    logic [1:0] a;
    check({tag, " channel_select"}, 32'(channel_select), mdl_valid ? 32'(mdl.chb[1:0]) : 32'h0);
    check({tag, " aline_select"}, 32'(aline_select), mdl_valid ? 32'(mdl.alb[1:0]) : 32'h0);
    check({tag, " pulse_shape"}, pulse_shape, mdl_valid ? mdl.ps : 32'h0);
    check({tag, " cfg_valid"}, 32'(cfg_valid), 32'(mdl_valid));
    for (int i = 0; i < 4; i++) begin
      a = 2'(i);
      rd_ch    = a[1];
      rd_aline = a[0];
      @(negedge clk);
      check({tag, " rd_data"}, 32'(rd_data), mdl_valid ? 32'(mdl.w[i]) : 32'h0);
    end
  endtask

  task automatic finish_frame(input cfg_t c, input bit good, input int ok0, input int err0,
                              input string tag);
    repeat (5) @(negedge clk);
    if (good) begin
      mdl       = c;
      mdl_valid = 1'b1;
    end
    check({tag, " frame_ok pulses"}, 32'(ok_cnt - ok0), good ? 32'd1 : 32'd0);
    check({tag, " frame_err pulses"}, 32'(err_cnt - err0), good ? 32'd0 : 32'd1);
    check({tag, " intaking_configs"}, 32'(intaking_configs), 32'h0);
    check_all(tag);
    $display("frame %s: good=%0d ok=%0d err=%0d ps=%08h", tag, good,
             ok_cnt - ok0, err_cnt - err0, pulse_shape);
  endtask

  task automatic run_frame(input cfg_t c, input bit good, input int hlo, input int hhi,
                           input int ghi, input string tag);
    int ok0, err0;
`ifdef CFG_CHECKSUM_EN
    csum_flip = good ? 8'h00 : 8'($urandom_range(255, 1));
`endif
    build_frame(c);
    ok0 = ok_cnt;
    err0 = err_cnt;
    send_range(0, frame_q.size() - 1, hlo, hhi, 1, ghi);
    finish_frame(c, good, ok0, err0, tag);
  endtask

  initial begin
    cfg_t    plan, c;
    rd_vec_t rd_tab [4];
    int      ok0, err0, n, kok, nok;
    logic    fo [8];
    logic [15:0] rdv [8];
    logic [15:0] old_w, new_w;
    logic [7:0]  junk;

    plan.chb = 8'h03;
    plan.alb = 8'h01;
    plan.ps  = 32'hDEADBEEF;
    plan.w[0] = 16'h1111;
    plan.w[1] = 16'h2222;
    plan.w[2] = 16'h3333;
    plan.w[3] = 16'h4444;
    rd_tab[0] = '{ch: 1'b0, al: 1'b0, exp: 16'h1111};
    rd_tab[1] = '{ch: 1'b0, al: 1'b1, exp: 16'h2222};
    rd_tab[2] = '{ch: 1'b1, al: 1'b0, exp: 16'h3333};
    rd_tab[3] = '{ch: 1'b1, al: 1'b1, exp: 16'h4444};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset rd_data", 32'(rd_data), 32'h0);
    check("reset intaking", 32'(intaking_configs), 32'h0);
    check("reset channel_select", 32'(channel_select), 32'h0);
    check("reset aline_select", 32'(aline_select), 32'h0);
    check("reset pulse_shape", pulse_shape, 32'h0);
    check("reset cfg_valid", 32'(cfg_valid), 32'h0);
    check("reset frame_ok", 32'(frame_ok), 32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    rst = 1'b0;

`ifdef CFG_CHECKSUM_EN
    // Corrupted checksum: rejected, nothing committed
    run_frame(plan, 1'b0, 1, 1, 1, "bad_csum");
`endif

    // Reference frame, with intaking_configs checked right after SYNC
`ifdef CFG_CHECKSUM_EN
    csum_flip = 8'h00;
`endif
    build_frame(plan);
    ok0 = ok_cnt;
    err0 = err_cnt;
    send_byte(frame_q[0], 1, 1);
    check("intaking after sync", 32'(intaking_configs), 32'h1);
    send_range(1, frame_q.size() - 1, 1, 1, 1, 1);
    finish_frame(plan, 1'b1, ok0, err0, "plan");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd_ch    = rd_tab[i].ch;
      rd_aline = rd_tab[i].al;
      @(negedge clk);
      check("plan table rd", 32'(rd_data), 32'(rd_tab[i].exp));
    end

    // Timeout after 5 payload bytes leaves the committed config alone
    c = rand_cfg();
    build_frame(c);
    ok0 = ok_cnt;
    err0 = err_cnt;
    send_range(0, 11, 1, 1, 1, 1);
    repeat (TIMEOUT_CYC / 2) @(negedge clk);
    check("timeout not early", 32'(err_cnt - err0), 32'h0);
    check("timeout intaking held", 32'(intaking_configs), 32'h1);
    repeat (TIMEOUT_CYC / 2 + 20) @(negedge clk);
    check("timeout frame_err", 32'(err_cnt - err0), 32'h1);
    check("timeout frame_ok", 32'(ok_cnt - ok0), 32'h0);
    check("timeout intaking", 32'(intaking_configs), 32'h0);
    check_all("timeout");
    $display("frame timeout: err=%0d", err_cnt - err0);

    // Long new_data pulses and junk bytes before SYNC
    send_byte(8'h00, 5, 1);
    send_byte(8'h7F, 5, 1);
    check("junk intaking", 32'(intaking_configs), 32'h0);
    run_frame(rand_cfg(), 1'b1, 5, 5, 1, "held_high");

    // Continuous read of (0,1) across a commit
    c = rand_cfg();
    c.w[1] = ~mdl.w[1];
    old_w = mdl.w[1];
    new_w = c.w[1];
`ifdef CFG_CHECKSUM_EN
    csum_flip = 8'h00;
`endif
    build_frame(c);
    @(negedge clk);
    rd_ch = 1'b0;
    rd_aline = 1'b1;
    ok0 = ok_cnt;
    n = frame_q.size();
    send_range(0, n - 2, 1, 1, 1, 1);
    @(negedge clk);
    uart_data = frame_q[n - 1];
    new_data  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      new_data = 1'b0;
      fo[k]  = frame_ok;
      rdv[k] = rd_data;
    end
    kok = -1;
    nok = 0;
    for (int k = 0; k < 8; k++) begin
      if (fo[k]) begin
        nok++;
        if (kok < 0) kok = k;
      end
    end
    check("switch frame_ok count", 32'(nok), 32'd1);
    check("switch frame_ok cycle", 32'(kok), 32'd1);
    for (int k = 0; k < 8; k++)
      check("switch rd_data", 32'(rdv[k]), (k <= 1) ? 32'(old_w) : 32'(new_w));
    mdl = c;
    $display("frame switch: old=%04h new=%04h frame_ok_cycle=%0d", old_w, new_w, kok);
    check_all("switch");

    // Reset in the middle of the payload
    c = rand_cfg();
    build_frame(c);
    send_range(0, 9, 1, 1, 1, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst intaking", 32'(intaking_configs), 32'h0);
    check("midrst cfg_valid", 32'(cfg_valid), 32'h0);
    check("midrst channel_select", 32'(channel_select), 32'h0);
    check("midrst aline_select", 32'(aline_select), 32'h0);
    check("midrst pulse_shape", pulse_shape, 32'h0);
    check("midrst rd_data", 32'(rd_data), 32'h0);
    rst = 1'b0;
    mdl_valid = 1'b0;
    run_frame(c, 1'b1, 1, 2, 2, "after_rst");

    // Randomized frames with idle junk, variable pulse widths and gaps
    for (int t = 0; t < 20; t++) begin
      for (int j = 0; j < int'($urandom_range(2, 0)); j++) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h00;
        send_byte(junk, $urandom_range(3, 1), $urandom_range(3, 1));
      end
`ifdef CFG_CHECKSUM_EN
      run_frame(rand_cfg(), ($urandom_range(3, 0) != 0), 1, 3, 3, $sformatf("rand%0d", t));
`else
      run_frame(rand_cfg(), 1'b1, 1, 3, 3, $sformatf("rand%0d", t));
`endif
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
